signed_mult_inv_sqrt2_seq: RTL

Sequential signed multiplier by the constant 1/sqrt(2) = 0.70711, approximated as 181/256. It computes p = a·181/2^8 using sign-magnitude arithmetic, so it is the inverse of the ×sqrt(2) scaling stage in the 2-D FHT datapath and undoes that gain on the inverse-transform and normalization path. The multiply is an 8-step shift-and-add over the constant bits. Input and output use valid/ready handshakes so the block can sit between buffered FHT stages.

---
 rtl/signed_mult_inv_sqrt2_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/signed_mult_inv_sqrt2_seq.sv
`default_nettype none
// ============================================================================
//  Module      : signed_mult_inv_sqrt2_seq
//  Description : Sequential signed multiplier by 1/sqrt(2) ~= 181/256.
//                Sign-magnitude, 8-step shift-and-add over the constant
//                bits, valid/ready handshake on input and output.
//                Optional macro SIGNED_MULT_INV_SQRT2_ROUND_EN selects
//                round-half-up of the magnitude instead of truncation.
//  Revision    : 1.0  initial release
// ============================================================================
module signed_mult_inv_sqrt2_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] p
);

    // Accumulator wide enough for |a| * 181 with |a| up to 2^(N-1)
    localparam int         c_ACC_W = N + 8;
    localparam logic [7:0] c_K     = 8'b1011_0101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_sgn;
    logic [N-1:0]         r_mag;
    logic [c_ACC_W-1:0]   r_acc;
    logic [2:0]           r_cnt;

    logic [c_ACC_W-1:0]   w_addend;
    logic [c_ACC_W-1:0]   w_sum;
    logic [c_ACC_W-1:0]   w_fin;
    logic [N-1:0]         w_m;
    logic [N-1:0]         w_p;
    logic [N-1:0]         w_a_mag;

    // Partial product for the current constant bit
    assign w_addend = c_K[r_cnt] ? ({8'd0, r_mag} << r_cnt) : '0;
    assign w_sum    = r_acc + w_addend;

`ifdef SIGNED_MULT_INV_SQRT2_ROUND_EN
    // Half-LSB bias on the magnitude gives rounding symmetric about zero;
    // it is folded into the final add so latency does not change
    assign w_fin = w_sum + c_ACC_W'(128);
`else
    assign w_fin = w_sum;
`endif

    // Drop the 8 fraction bits, then restore the sign (0 stays 0)
    assign w_m     = N'(w_fin >> 8);
    assign w_p     = r_sgn ? (~w_m + N'(1)) : w_m;

    // Magnitude of the operand; the most negative value maps to 2^(N-1)
    assign w_a_mag = a[N-1] ? (~a + N'(1)) : a;

    // Handshake outputs decode registered state only
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_sgn   <= 1'b0;
            r_mag   <= '0;
            r_acc   <= '0;
            r_cnt   <= 3'd0;
            p       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sgn   <= a[N-1];
                        r_mag   <= w_a_mag;
                        r_acc   <= '0;
                        r_cnt   <= 3'd0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        p       <= w_p;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
